// File: rtl/rr_mux_4_1_stage_if.sv
// rr_mux_4_1_stage_if: requester and output handshake bundle for the round-robin mux stage
interface rr_mux_4_1_stage_if #(parameter int WIDTH = 4);
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_sel;
   modport master (
      output d0, d1, d2, d3, in_valid, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
   modport slave (
      input  d0, d1, d2, d3, in_valid, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_mux_4_1_stage.sv
// rr_mux_4_1_stage: round-robin 4:1 arbitrating mux with a registered valid/ready output
module rr_mux_4_1_stage #(
   parameter int WIDTH = 4
) (
   input logic               clk,
   input logic               rst,
   rr_mux_4_1_stage_if.slave bus
);
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [1:0]       r_out_sel;
   logic [1:0]       r_last_grant;
   logic             w_load;
   logic             w_gnt_vld;
   logic [1:0]       w_gnt;
   logic [1:0]       w_idx;
   logic [WIDTH-1:0] w_data;
   assign w_load = !r_out_valid || bus.out_ready;
   // scan farthest-first so the nearest valid index after last_grant wins
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = 2'd0;
      w_idx     = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         w_idx = r_last_grant + 2'(k);
         if (bus.in_valid[w_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx;
         end
      end
   end
   assign w_data = (w_gnt == 2'd0) ? bus.d0 :
                   (w_gnt == 2'd1) ? bus.d1 :
                   (w_gnt == 2'd2) ? bus.d2 : bus.d3;
   assign bus.in_ready = (w_load && w_gnt_vld && !rst) ? (4'b0001 << w_gnt) : 4'b0000;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_sel    <= 2'd0;
         r_last_grant <= 2'd3;
      end else if (w_load) begin
         r_out_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_out_data   <= w_data;
            r_out_sel    <= w_gnt;
            r_last_grant <= w_gnt;
         end
      end
   end
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sel   = r_out_sel;
endmodule
